enc_cmd_queue: RTL and testbench
================================

// Module: enc_cmd_queue
// PURPOSE
//  Wishbone-side command front end for the LWE encrypt core. It sits upstream of the core.
//  - CPU writes a 32-bit instruction word to OPCODE_ADDR; the block decodes it and queues it in a CMD_DEPTH FIFO.
//  - It issues queued commands to the core with a valid/ready handshake, one command outstanding at a time.
//  - A status word (count, empty/full/busy, sticky error) is readable at STATUS_ADDR.
// PARAMETERS
//  ADDR_WIDTH   10            width of each operand/destination address field
//  OPCODE_ADDR  32'h30000000  WB address that accepts instruction writes
//  STATUS_ADDR  32'h30000004  WB address of status (read) / error clear (write)
//  CMD_DEPTH    4             FIFO entries; power of two, >=2
// PORTS
//  wb_clk_i    in   1   clock (only clock)
//  wb_rst_ni   in   1   asynchronous active-low reset
//  wbs_stb_i   in   1   WB strobe
//  wbs_cyc_i   in   1   WB cycle
//  wbs_we_i    in   1   WB write enable
//  wbs_sel_i   in   4   WB byte select; writes require 4'b1111, otherwise acked and ignored
//  wbs_adr_i   in   32  WB address
//  wbs_dat_i   in   32  WB write data
//  wbs_ack_o   out  1   WB acknowledge (registered)
//  wbs_dat_o   out  32  WB read data; zero unless acking a STATUS_ADDR read
//  cmd_valid_o out  1   command presented to core
//  cmd_ready_i in   1   core accepts command
//  cmd_op_o    out  2   opcode
//  cmd_src_a_o out  ADDR_WIDTH  operand A address
//  cmd_src_b_o out  ADDR_WIDTH  operand B address
//  cmd_dst_o   out  ADDR_WIDTH  result address
//  cmd_done_i  in   1   one-cycle pulse from core: command finished
//  busy_o      out  1   a command has been issued and cmd_done_i not yet seen
// BEHAVIOUR
//  Reset (async, wb_rst_ni=0): all outputs 0; FIFO empty; FSM=IDLE; err=0; accept flag=0.
//  Instruction format: [1:0] op, [ADDR_WIDTH+1:2] src_a, [2*ADDR_WIDTH+1:ADDR_WIDTH+2] src_b,
//   [3*ADDR_WIDTH+1:2*ADDR_WIDTH+2] dst. Bits above 3*ADDR_WIDTH+1 are ignored.
//  WB hit: stb&cyc and adr in {OPCODE_ADDR, STATUS_ADDR}. Other addresses get no ack and no side effect.
//  WB accept rules:
//   - A transaction is accepted on a hit cycle with the accept flag clear.
//   - wbs_ack_o=1 on the next cycle, for exactly 1 cycle; the accept flag is then set.
//   - The flag clears when stb drops. One stb assertion therefore yields exactly one ack and at most one push.
//  Writes to OPCODE_ADDR:
//   - FIFO full: not accepted; ack is stalled until an entry frees.
//   - op==2'b11 (reserved): acked, not pushed, err set.
//   - Otherwise pushed at the accept cycle.
//  Reads of OPCODE_ADDR return 0.
//  STATUS_ADDR read: dat_o[7:0]=count, [8]=empty, [9]=full, [10]=busy_o, [11]=err, other bits 0.
//   Value is sampled at the accept cycle and driven with the ack.
//  STATUS_ADDR write: dat_i[11]=1 clears err (W1C). Other bits are ignored.
//  Issue FSM:
//   - IDLE: FIFO non-empty -> ISSUE.
//   - ISSUE: cmd_valid_o=1; cmd_* = FIFO head, held stable until ready. On cmd_valid_o&cmd_ready_i: pop; -> WAIT, busy_o=1.
//   - WAIT: cmd_done_i -> busy_o=0 and IDLE. cmd_done_i in any other state is ignored.
//  Latency: push to cmd_valid_o is 2 cycles from the accept edge (empty FIFO, IDLE).
//  Simultaneous push and pop: both occur. A push while full is impossible because the full FIFO stalls the ack.
//   Count is unchanged.
//  Pointers wrap modulo CMD_DEPTH; count ranges 0..CMD_DEPTH.
//  Reset mid-operation: FIFO contents discarded; any in-flight ack is dropped; cmd_valid_o and busy_o drop immediately.
// TESTING
//  1. Reset -> all outputs 0; read STATUS_ADDR -> dat_o=32'h100 (empty).
//  2. Write 32'h0C864000 to OPCODE_ADDR, stb held 3 cycles -> exactly one ack.
//     cmd_valid_o, op=0, src_a=0, src_b=100, dst=50. Ready=1 -> busy_o=1. Done pulse -> busy_o=0.
//  3. Hold cmd_ready_i=0 and write 5 commands -> first 4 acked. 5th ack stalls with status full=1, count=4.
//     Then ready=1 -> 5th acked; commands issue in write order.
//  4. Write op=2'b11 -> acked; no cmd_valid_o; status bit 11=1. Write 32'h800 to STATUS_ADDR -> bit 11=0.
//  5. Access to address 32'h10000000 -> no ack for 8 cycles; count unchanged.
//  6. Assert wb_rst_ni=0 in WAIT with 2 queued -> busy_o=0, cmd_valid_o=0, and status count=0 after release.

Source files
------------

// File: rtl/enc_cmd_queue.sv
// enc_cmd_queue: Wishbone command front end for the LWE encrypt core.
//   The CPU writes instruction words to OPCODE_ADDR. Each word is decoded and queued
//   in a CMD_DEPTH-entry FIFO. Queued commands are issued to the core one at a time
//   over a valid/ready handshake. A status word is read, and the sticky error is
//   cleared, at STATUS_ADDR.
// Ports:
//   wb_clk_i, wb_rst_ni       clock, asynchronous active-low reset
//   wbs_*                     Wishbone slave (registered ack, read data zero unless acking)
//   cmd_valid_o/cmd_ready_i   command handshake towards the core
//   cmd_op_o/src_a/src_b/dst  fields of the command at the FIFO head (zero when not valid)
//   cmd_done_i                one-cycle completion pulse from the core
//   busy_o                    a command has been issued and its completion not yet seen
module enc_cmd_queue #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] OPCODE_ADDR = 32'h3000_0000,
  parameter logic [31:0] STATUS_ADDR = 32'h3000_0004,
  parameter int unsigned CMD_DEPTH   = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [1:0]            cmd_op_o,
  output logic [ADDR_WIDTH-1:0] cmd_src_a_o,
  output logic [ADDR_WIDTH-1:0] cmd_src_b_o,
  output logic [ADDR_WIDTH-1:0] cmd_dst_o,
  input  logic                  cmd_done_i,
  output logic                  busy_o
);

  localparam int unsigned EW = 3 * ADDR_WIDTH + 2;
  localparam int unsigned PW = $clog2(CMD_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic [EW-1:0] mem [CMD_DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty, fifo_full;
  logic          acc_flag, err;
  logic          hit_opc, hit_stat, full_wr, accept, push, pop;
  logic [31:0]   status;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(CMD_DEPTH));

  assign hit_opc  = wbs_stb_i && wbs_cyc_i && (wbs_adr_i == OPCODE_ADDR);
  assign hit_stat = wbs_stb_i && wbs_cyc_i && (wbs_adr_i == STATUS_ADDR);
  assign full_wr  = wbs_we_i && (wbs_sel_i == 4'b1111);

  // A full-word instruction write against a full FIFO is held off (no ack) until a pop
  // frees an entry, so a push can never collide with a full FIFO.
  assign accept = (hit_opc || hit_stat) && !acc_flag && !(hit_opc && full_wr && fifo_full);
  assign push   = accept && hit_opc && full_wr && (wbs_dat_i[1:0] != 2'b11);
  assign pop    = cmd_valid_o && cmd_ready_i;

  assign status = {20'b0, err, busy_o, fifo_full, fifo_empty, 8'(count)};

  // Wishbone response, accept flag and sticky error
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      acc_flag  <= 1'b0;
      err       <= 1'b0;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= (accept && hit_stat && !wbs_we_i) ? status : '0;
      if (accept)
        acc_flag <= 1'b1;
      else if (!wbs_stb_i)
        acc_flag <= 1'b0;
      if (accept && hit_opc && full_wr && (wbs_dat_i[1:0] == 2'b11))
        err <= 1'b1;
      else if (accept && hit_stat && full_wr && wbs_dat_i[11])
        err <= 1'b0;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem[wr_ptr] <= wbs_dat_i[EW-1:0];
  end

  assign head = mem[rd_ptr];

  // Issue FSM
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty)
          state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i)
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (cmd_done_i)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Head fields stay stable while presented: pushes never target the head slot.
  assign cmd_op_o    = cmd_valid_o ? head[1:0] : '0;
  assign cmd_src_a_o = cmd_valid_o ? head[ADDR_WIDTH+1:2] : '0;
  assign cmd_src_b_o = cmd_valid_o ? head[2*ADDR_WIDTH+1:ADDR_WIDTH+2] : '0;
  assign cmd_dst_o   = cmd_valid_o ? head[3*ADDR_WIDTH+1:2*ADDR_WIDTH+2] : '0;

endmodule

// File: tb/tb_enc_cmd_queue.sv
module tb_enc_cmd_queue;

  localparam logic [31:0] OPC   = 32'h3000_0000;
  localparam logic [31:0] STA   = 32'h3000_0004;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stb, cyc, we, ready, done;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack, valid, busy;
  logic [31:0] dato;
  logic [1:0]  op;
  logic [9:0]  sa, sb, sd;

  enc_cmd_queue #(
    .ADDR_WIDTH (10),
    .OPCODE_ADDR(OPC),
    .STATUS_ADDR(STA),
    .CMD_DEPTH  (DEPTH)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dato),
    .cmd_valid_o(valid),
    .cmd_ready_i(ready),
    .cmd_op_o   (op),
    .cmd_src_a_o(sa),
    .cmd_src_b_o(sb),
    .cmd_dst_o  (sd),
    .cmd_done_i (done),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Reference model: queued instruction words with the cycle each was accepted,
  // an in-flight flag, and the cycle the core last reported completion.
  logic [31:0] q[$];
  int          pc[$];
  bit          inflight, flag, err, auto_core;
  int          free_cyc, t;
  logic        e_ack;
  logic [31:0] e_dat;
  int          total, bad;

  logic        s_ack, s_valid, s_busy;
  logic [31:0] s_dat;
  logic [1:0]  s_op;
  logic [9:0]  s_sa, s_sb, s_sd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 50)
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, t);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] o, input logic [9:0] a,
                                      input logic [9:0] b, input logic [9:0] d2);
    return {d2, b, a, o};
  endfunction

  task automatic model_step();
    bit          ev, hit, wfull, acc;
    int          n, ready_at;
    logic [31:0] h, st;
    t++;
    if (!rst_n) begin
      q.delete();
      pc.delete();
      inflight = 1'b0;
      flag     = 1'b0;
      err      = 1'b0;
      free_cyc = -100;
      e_ack    = 1'b0;
      e_dat    = '0;
    end
    // A command is shown two cycles after it was accepted, and no earlier than two
    // cycles after the previous command completed.
    ev = 1'b0;
    h  = '0;
    if (q.size() > 0 && !inflight) begin
      ready_at = (pc[0] > free_cyc) ? pc[0] : free_cyc;
      ev = (t >= ready_at + 2);
      if (ev) h = q[0];
    end
    chk("ack", 32'(ack), 32'(e_ack));
    chk("rdata", dato, e_dat);
    chk("cmd_valid", 32'(valid), 32'(ev));
    chk("cmd_op", 32'(op), 32'(h[1:0]));
    chk("cmd_src_a", 32'(sa), 32'(h[11:2]));
    chk("cmd_src_b", 32'(sb), 32'(h[21:12]));
    chk("cmd_dst", 32'(sd), 32'(h[31:22]));
    chk("busy", 32'(busy), 32'(inflight));
    s_ack = ack; s_dat = dato; s_valid = valid; s_busy = busy;
    s_op = op; s_sa = sa; s_sb = sb; s_sd = sd;
    if (!rst_n) return;

    n     = q.size();
    hit   = stb && cyc && (adr == OPC || adr == STA);
    wfull = we && (sel == 4'hF);
    acc   = hit && !flag && !(adr == OPC && wfull && n == DEPTH);
    st    = (32'(err) << 11) | (32'(inflight) << 10) | ((n == DEPTH) ? 32'h200 : 32'h0)
          | ((n == 0) ? 32'h100 : 32'h0) | 32'(n);
    e_ack = acc;
    e_dat = (acc && !we && adr == STA) ? st : 32'h0;
    if (ev && ready) begin
      void'(q.pop_front());
      void'(pc.pop_front());
      inflight = 1'b1;
    end else if (inflight && done) begin
      inflight = 1'b0;
      free_cyc = t;
    end
    if (acc && adr == OPC && wfull) begin
      if (dat[1:0] == 2'b11) err = 1'b1;
      else begin
        q.push_back(dat);
        pc.push_back(t);
      end
    end
    if (acc && adr == STA && wfull && dat[11]) err = 1'b0;
    if (acc) flag = 1'b1;
    else if (!stb) flag = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (auto_core) begin
      ready = ($urandom_range(0, 1) == 1);
      done  = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
    end
  endtask

  // hold=1: keep the strobe up for exactly 'budget' cycles; hold=0: drop it after the ack.
  task automatic wb(input logic [31:0] a, input logic w, input logic [31:0] d,
                    input logic [3:0] s, input int unsigned budget, input bit hold,
                    output int acks, output logic [31:0] rd);
    adr = a; we = w; dat = d; sel = s; stb = 1'b1; cyc = 1'b1;
    acks = 0;
    rd = '0;
    for (int unsigned i = 0; i < budget; i++) begin
      cycle();
      if (s_ack) begin
        acks++;
        rd = s_dat;
        if (!hold) break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    cycle();
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    int          acks;
    logic [31:0] v;
    wb(STA, 1'b0, 32'h0, 4'hF, 20, 1'b0, acks, v);
    chk({name, "_ack"}, 32'(acks), 32'd1);
    chk(name, v, exp);
  endtask

  task automatic drain();
    auto_core = 1'b1;
    for (int unsigned i = 0; i < 500 && (q.size() > 0 || inflight); i++) cycle();
    auto_core = 1'b0;
    ready = 1'b0;
    done  = 1'b0;
    cycle();
    chk("drain_timeout", 32'(q.size()) + 32'(inflight), 32'd0);
  endtask

  initial begin
    int          acks;
    logic [31:0] v, d;
    int unsigned r;
    stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; dat = 0; ready = 0; done = 0;
    auto_core = 0; total = 0; bad = 0; t = 0; free_cyc = -100;
    inflight = 0; flag = 0; err = 0; e_ack = 0; e_dat = 0;
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // Reset status
    rd_status("t1_status", 32'h100);

    // Single command, strobe held 3 cycles
    wb(OPC, 1'b1, 32'h0C86_4000, 4'hF, 3, 1'b1, acks, v);
    chk("t2_one_ack", 32'(acks), 32'd1);
    for (int unsigned i = 0; i < 10 && !s_valid; i++) cycle();
    chk("t2_valid", 32'(s_valid), 32'd1);
    chk("t2_op", 32'(s_op), 32'd0);
    chk("t2_src_a", 32'(s_sa), 32'd0);
    chk("t2_src_b", 32'(s_sb), 32'd100);
    chk("t2_dst", 32'(s_sd), 32'd50);
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    cycle();
    chk("t2_busy", 32'(s_busy), 32'd1);
    done = 1'b1;
    cycle();
    done = 1'b0;
    cycle();
    chk("t2_busy_clr", 32'(s_busy), 32'd0);

    // Fill the FIFO with the core stalled
    for (int unsigned k = 0; k < 4; k++) begin
      wb(OPC, 1'b1, mk(2'(k % 3), 10'(10 * k + 1), 10'(20 * k + 2), 10'(30 * k + 3)),
         4'hF, 20, 1'b0, acks, v);
      chk("t3_ack", 32'(acks), 32'd1);
    end
    rd_status("t3_status_full", 32'h204);
    adr = OPC; we = 1'b1; dat = mk(2'd2, 10'd511, 10'd512, 10'd1023); sel = 4'hF;
    stb = 1'b1; cyc = 1'b1;
    acks = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      cycle();
      if (s_ack) acks++;
    end
    chk("t3_stall", 32'(acks), 32'd0);
    ready = 1'b1;
    for (int unsigned i = 0; i < 30 && acks == 0; i++) begin
      cycle();
      if (s_ack) acks++;
    end
    chk("t3_fifth_ack", 32'(acks), 32'd1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; ready = 1'b0;
    cycle();
    drain();

    // Reserved opcode, partial byte select, error clear
    wb(OPC, 1'b1, 32'h0000_0007, 4'hF, 20, 1'b0, acks, v);
    chk("t4_ack", 32'(acks), 32'd1);
    wb(OPC, 1'b1, 32'h0000_0001, 4'b0011, 20, 1'b0, acks, v);
    chk("t4_sel_ack", 32'(acks), 32'd1);
    repeat (4) cycle();
    chk("t4_no_valid", 32'(s_valid), 32'd0);
    rd_status("t4_status_err", 32'h900);
    wb(STA, 1'b1, 32'h0000_0800, 4'hF, 20, 1'b0, acks, v);
    chk("t4_clr_ack", 32'(acks), 32'd1);
    rd_status("t4_status_clr", 32'h100);

    // Unmapped address
    wb(32'h1000_0000, 1'b1, 32'h0000_0001, 4'hF, 8, 1'b1, acks, v);
    chk("t5_no_ack_wr", 32'(acks), 32'd0);
    wb(32'h1000_0000, 1'b0, 32'h0, 4'hF, 8, 1'b1, acks, v);
    chk("t5_no_ack_rd", 32'(acks), 32'd0);
    rd_status("t5_status", 32'h100);

    // Reset while a command is in flight with two queued
    ready = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      wb(OPC, 1'b1, mk(2'(k), 10'(k + 5), 10'(k + 6), 10'(k + 7)), 4'hF, 20, 1'b0, acks, v);
      chk("t6_ack", 32'(acks), 32'd1);
    end
    repeat (3) cycle();
    rd_status("t6_status_pre", 32'h402);
    rst_n = 1'b0;
    cycle();
    chk("t6_busy_rst", 32'(s_busy), 32'd0);
    chk("t6_valid_rst", 32'(s_valid), 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    ready = 1'b0;
    cycle();
    rd_status("t6_status_post", 32'h100);

    // Randomized traffic against the model
    auto_core = 1'b1;
    for (int unsigned n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      d = $urandom;
      if (r < 5) begin
        adr = OPC;
        if ($urandom_range(0, 7) != 0) d[1:0] = 2'($urandom_range(0, 2));
      end else if (r < 8) adr = STA;
      else adr = (r == 8) ? 32'h1000_0000 : 32'h3000_0008;
      sel = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if (r < 8) begin
        wb(adr, ($urandom_range(0, 3) != 0), d, sel, 80, 1'b0, acks, v);
        chk("rnd_ack", 32'(acks), 32'd1);
      end else begin
        wb(adr, ($urandom_range(0, 1) == 1), d, sel, 4, 1'b1, acks, v);
        chk("rnd_unmapped", 32'(acks), 32'd0);
      end
      repeat ($urandom_range(0, 2)) cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
